cache_mem_ctrl: RTL and testbench
=================================

// Module: cache_mem_ctrl
// PURPOSE
//  Memory-side miss handler for the direct-mapped write-back cache (32 lines x 256-bit blocks).
//  Consumes miss/need_writeback/wb_address/wb_block_data and writes back dirty victims to main memory.
//  Fetches the missing block as 8 word beats over a req/ack bus, then returns it via refill_block + refill_done.
//  Sits between the cache and main memory; holds the CPU via stall.
// PARAMETERS
//  ADDR_W           16   byte address width
//  WORD_W           32   memory bus data width
//  WORDS_PER_BLOCK  8    beats per block; BLOCK_W = WORD_W*WORDS_PER_BLOCK = 256
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  miss           in   1      cache miss on current access (combinational from cache)
//  need_writeback in   1      victim line valid and dirty
//  address        in   16     CPU access address; held stable by CPU while stall=1
//  wb_address     in   16     victim block base address
//  wb_block_data  in   256    victim block data
//  refill_block   out  256    fetched block; word k at [k*32 +: 32]
//  refill_done    out  1      one-cycle pulse: cache installs refill_block at this edge
//  stall          out  1      CPU hold
//  mem_req        out  1      memory request, held until accepted
//  mem_we         out  1      1 = write beat, 0 = read beat
//  mem_addr       out  16     word-aligned beat address
//  mem_wdata      out  32     write beat data
//  mem_rdata      in   32     read beat data, valid when mem_ack=1
//  mem_ack        in   1      beat accepted/completed this cycle
// BEHAVIOUR
//  Reset: state IDLE; refill_block=0, refill_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, beat=0.
//  FSM: IDLE -> WB (miss && need_writeback) | RD (miss && !need_writeback); WB -> RD after beat 7 acked;
//   RD -> DONE after beat 7 acked; DONE -> IDLE unconditionally.
//  On IDLE exit: latch rd_base = {address[15:5],5'b0}, wb_base = {wb_address[15:5],5'b0},
//   and wb_buf = wb_block_data; later changes to these inputs are ignored until next IDLE.
//  Beat handshake: mem_req/mem_we/mem_addr/mem_wdata registered and stable until a cycle with
//   mem_req && mem_ack; transfer completes in that cycle; ack may arrive in the cycle req rises or later.
//  mem_ack while mem_req=0 is ignored.
//  mem_addr = base | {beat,2'b00}. WB: mem_we=1, mem_wdata = wb_buf[beat*32 +: 32].
//  RD: mem_we=0; on ack, refill_block[beat*32 +: 32] <= mem_rdata.
//  beat: 3-bit, increments per completed beat; 7 -> 0 wraps with the state change.
//  The next beat's request is presented the cycle after ack. Throughput is 1 beat / 2 cycles minimum.
//  mem_req=0 in IDLE and DONE; no bubble beyond that between WB beat 7 and RD beat 0.
//  DONE: refill_done=1 for exactly one cycle; refill_block holds until the next RD phase overwrites it.
//  Cache reports hit the cycle after refill_done, so IDLE does not re-trigger.
//  stall = miss | (state != IDLE). This is combinational so the first miss cycle already stalls.
//  Minimum latency, miss cycle to refill_done (ack same cycle as req): no WB = 17 cycles; with WB = 33 cycles.
//  Reset mid-operation: immediate return to IDLE, mem_req drops asynchronously.
//   A partial writeback is abandoned, no refill_done is issued, and no partial data reaches the cache.
//  miss while in WB/RD/DONE is not re-sampled; only IDLE accepts a new miss.
// STRUCTURE
//  cache_pkg: typedef enum {IDLE,WB,RD,DONE} mem_ctrl_state_t.
//   Also holds TAG_W=6, INDEX_W=5, OFFSET_W=5, WORDS_PER_BLOCK=8, BLOCK_W=256, and shared with the cache.
//  No sub-module. Flat is natural: one FSM, one beat counter, one 256-bit wb_buf, one 256-bit refill register.
// TESTING
//  1. Clean miss: addr=0x1234, need_wb=0, memory acks immediately with rdata=0xA0+k
//   -> 8 reads at 0x1220..0x123C, refill_block word k = 0xA0+k.
//   -> refill_done pulses once 17 cycles after miss; stall high throughout.
//  2. Dirty miss: wb_address=0x0420, wb_block_data word k = 0x5500+k, addr=0x8420
//   -> writes 0x5500..0x5507 to 0x0420..0x043C, then 8 reads at 0x8420..0x843C, then refill_done.
//  3. Backpressure: mem_ack delayed 3 cycles on every beat
//   -> mem_req/mem_addr/mem_wdata stay stable while waiting; no beat is skipped or duplicated.
//   -> latency grows by 24 cycles (no-WB case).
//  4. Change address and wb_block_data mid-WB -> beats still use the values latched at miss entry.
//  5. Assert rst during RD beat 4 -> mem_req=0 and state IDLE at once; no refill_done.
//   -> A new miss after reset starts at beat 0.
//  6. Spurious mem_ack in IDLE and DONE -> no state, beat or refill_block change.

Source files
------------

// File: rtl/cache_mem_ctrl_pkg.sv
// Shared cache geometry and miss-handler state encoding.
// Imported by the cache, the memory bus interface and the controller.
package cache_pkg;

    localparam int ADDR_W          = 16;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
    localparam int TAG_W           = 6;
    localparam int INDEX_W         = 5;
    localparam int OFFSET_W        = 5;
    localparam int BEAT_W          = 3;

    localparam logic [ADDR_W-1:0] BASE_MASK = 16'hFFE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } mem_ctrl_state_t;

endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Word-wide req/ack bus between the miss handler and main memory.
// master = controller side, slave = memory side.
interface cache_mem_ctrl_if;
    import cache_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/cache_mem_ctrl.sv
// Miss handler: writes back a dirty victim, then fetches the missing
// block as 8 word beats and hands it to the cache with refill_done.
module cache_mem_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               miss,
    input  logic               need_writeback,
    input  logic [ADDR_W-1:0]  address,
    input  logic [ADDR_W-1:0]  wb_address,
    input  logic [BLOCK_W-1:0] wb_block_data,
    output logic [BLOCK_W-1:0] refill_block,
    output logic               refill_done,
    output logic               stall,
    cache_mem_ctrl_if.master   mem
);

    mem_ctrl_state_t    state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0]  rd_base_q, rd_base_d;
    logic [ADDR_W-1:0]  wb_base_q, wb_base_d;
    logic [BLOCK_W-1:0] wb_buf_q, wb_buf_d;
    logic [BLOCK_W-1:0] refill_q, refill_d;

    logic [ADDR_W-1:0]  beat_off;
    logic [7:0]         beat_bit;

    assign beat_off = {11'd0, beat_q, 2'b00};
    assign beat_bit = {beat_q, 5'd0};

    // Next-state, beat sequencing and bus register updates.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_base_d = rd_base_q;
        wb_base_d = wb_base_q;
        wb_buf_d  = wb_buf_q;
        refill_d  = refill_q;

        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    rd_base_d = address & BASE_MASK;
                    wb_base_d = wb_address & BASE_MASK;
                    wb_buf_d  = wb_block_data;
                    beat_d    = '0;
                    req_d     = 1'b1;
                    if (need_writeback) begin
                        state_d = WB;
                        we_d    = 1'b1;
                        addr_d  = wb_address & BASE_MASK;
                        wdata_d = wb_block_data[WORD_W-1:0];
                    end else begin
                        state_d = RD;
                        we_d    = 1'b0;
                        addr_d  = address & BASE_MASK;
                    end
                end
            end
            WB, RD: begin
                if (req_q) begin
                    if (mem.mem_ack) begin
                        req_d  = 1'b0;
                        beat_d = beat_q + 3'd1;
                        if (state_q == RD) begin
                            refill_d[beat_bit +: WORD_W] = mem.mem_rdata;
                        end
                        if (beat_q == 3'd7) begin
                            state_d = (state_q == WB) ? RD : DONE;
                        end
                    end
                end else begin
                    // Gap cycle after an ack: present the next beat.
                    req_d = 1'b1;
                    if (state_q == WB) begin
                        we_d    = 1'b1;
                        addr_d  = wb_base_q | beat_off;
                        wdata_d = wb_buf_q[beat_bit +: WORD_W];
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = rd_base_q | beat_off;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_base_q <= '0;
            wb_base_q <= '0;
            wb_buf_q  <= '0;
            refill_q  <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_base_q <= rd_base_d;
            wb_base_q <= wb_base_d;
            wb_buf_q  <= wb_buf_d;
            refill_q  <= refill_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign refill_block = refill_q;
    assign refill_done  = (state_q == DONE);
    assign stall        = miss | (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a delay-programmable
// memory responder and a beat log.
module tb_cache_mem_ctrl;
    import cache_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               miss;
    logic               need_writeback;
    logic [15:0]        address;
    logic [15:0]        wb_address;
    logic [255:0]       wb_block_data;
    logic [255:0]       refill_block;
    logic               refill_done;
    logic               stall;

    cache_mem_ctrl_if mem ();

    cache_mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .miss           (miss),
        .need_writeback (need_writeback),
        .address        (address),
        .wb_address     (wb_address),
        .wb_block_data  (wb_block_data),
        .refill_block   (refill_block),
        .refill_done    (refill_done),
        .stall          (stall),
        .mem            (mem.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        model_ack;
    logic        spur_ack;
    int          ack_delay;
    logic [31:0] rdpat;
    assign mem.mem_ack = model_ack | spur_ack;

    logic [15:0] lg_addr[$];
    logic        lg_we[$];
    logic [31:0] lg_data[$];

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay waiting cycles, logs beats,
    // and checks the request stays stable while it waits.
    initial begin
        int          wcnt;
        logic [15:0] h_addr;
        logic [31:0] h_data;
        logic        h_we;
        wcnt = 0;
        model_ack = 1'b0;
        mem.mem_rdata = '0;
        h_addr = '0;
        h_data = '0;
        h_we = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mem.mem_req) begin
                model_ack = 1'b0;
                wcnt = 0;
            end else begin
                if (wcnt == 0) begin
                    h_addr = mem.mem_addr;
                    h_data = mem.mem_wdata;
                    h_we = mem.mem_we;
                end else begin
                    check("stable_addr", 256'(mem.mem_addr), 256'(h_addr));
                    check("stable_we", 256'(mem.mem_we), 256'(h_we));
                    if (h_we)
                        check("stable_wdata", 256'(mem.mem_wdata),
                              256'(h_data));
                end
                if (wcnt >= ack_delay) begin
                    model_ack = 1'b1;
                    mem.mem_rdata = rdpat + 32'(mem.mem_addr[4:2]);
                    lg_addr.push_back(mem.mem_addr);
                    lg_we.push_back(mem.mem_we);
                    lg_data.push_back(mem.mem_wdata);
                    wcnt = 0;
                end else begin
                    model_ack = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic        nwb;
        logic [15:0] wb_addr;
        logic [31:0] wbpat;
        logic [31:0] rpat;
        int          delay;
        logic        change_mid;
        logic [15:0] exp_wb_base;
        logic [15:0] exp_rd_base;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [255:0] mk_block(input logic [31:0] pat);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = pat + 32'(k);
        return b;
    endfunction

    task automatic clear_log();
        lg_addr.delete();
        lg_we.delete();
        lg_data.delete();
    endtask

    // Runs one miss from its first cycle (cycle 1) to refill_done.
    task automatic run_miss(input vec_t v, input logic spur_in_done);
        int cyc;
        int lat;
        int nb;
        clear_log();
        ack_delay = v.delay;
        rdpat = v.rpat;
        @(negedge clk);
        miss = 1'b1;
        need_writeback = v.nwb;
        address = v.addr;
        wb_address = v.wb_addr;
        wb_block_data = mk_block(v.wbpat);
        cyc = 1;
        lat = -1;
        #1;
        check("stall_first", 256'(stall), 256'(1));
        while (cyc < 300 && lat < 0) begin
            @(negedge clk);
            cyc++;
            if (v.change_mid && cyc == 5) begin
                address = ~v.addr;
                wb_address = ~v.wb_addr;
                wb_block_data = mk_block(32'hDEAD0000);
            end
            if (!stall) begin
                checks++;
                errors++;
                $display("FAIL stall_hold: dropped at cycle %0d", cyc);
            end
            if (refill_done) lat = cyc;
        end
        check("latency", 256'(lat), 256'(v.exp_lat));
        miss = 1'b0;
        if (spur_in_done) spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        check("done_pulse", 256'(refill_done), 256'(0));
        check("stall_idle", 256'(stall), 256'(0));
        check("req_idle", 256'(mem.mem_req), 256'(0));
        nb = v.nwb ? 16 : 8;
        check("beat_count", 256'(lg_addr.size()), 256'(nb));
        if (lg_addr.size() == nb) begin
            for (int i = 0; i < nb; i++) begin
                if (v.nwb && i < 8) begin
                    check("wb_addr", 256'(lg_addr[i]),
                          256'(v.exp_wb_base + 16'(4*i)));
                    check("wb_we", 256'(lg_we[i]), 256'(1));
                    check("wb_data", 256'(lg_data[i]),
                          256'(v.wbpat + 32'(i)));
                end else begin
                    check("rd_addr", 256'(lg_addr[i]),
                          256'(v.exp_rd_base + 16'(4*(i % 8))));
                    check("rd_we", 256'(lg_we[i]), 256'(0));
                end
            end
        end
        check("refill_block", refill_block, mk_block(v.rpat));
    endtask

    initial begin
        vec_t        r;
        logic [255:0] hold;
        vecs[0] = '{16'h1234, 1'b0, 16'h0000, 32'h0, 32'hA0, 0, 1'b0,
                    16'h0000, 16'h1220, 17};
        vecs[1] = '{16'h8420, 1'b1, 16'h0420, 32'h5500, 32'hB0, 0, 1'b0,
                    16'h0420, 16'h8420, 33};
        vecs[2] = '{16'h00FF, 1'b0, 16'h0000, 32'h0, 32'hC0, 3, 1'b0,
                    16'h0000, 16'h00E0, 41};
        vecs[3] = '{16'hFFFF, 1'b1, 16'h7FF3, 32'h7700, 32'hD0, 1, 1'b1,
                    16'h7FE0, 16'hFFE0, 49};
        vecs[4] = '{16'h4000, 1'b1, 16'h2000, 32'h9900, 32'hE0, 2, 1'b0,
                    16'h2000, 16'h4000, 65};

        rst = 1'b1;
        miss = 1'b0;
        need_writeback = 1'b0;
        address = '0;
        wb_address = '0;
        wb_block_data = '0;
        spur_ack = 1'b0;
        ack_delay = 0;
        rdpat = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 256'(mem.mem_req), 256'(0));
        check("rst_we", 256'(mem.mem_we), 256'(0));
        check("rst_addr", 256'(mem.mem_addr), 256'(0));
        check("rst_wdata", 256'(mem.mem_wdata), 256'(0));
        check("rst_done", 256'(refill_done), 256'(0));
        check("rst_refill", refill_block, 256'(0));
        check("rst_stall", 256'(stall), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_miss(vecs[i], i == 2);

        // Spurious acks while idle must not move anything.
        hold = refill_block;
        spur_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spur_req", 256'(mem.mem_req), 256'(0));
            check("spur_stall", 256'(stall), 256'(0));
            check("spur_refill", refill_block, hold);
        end
        spur_ack = 1'b0;

        // Reset while read beat 4 is on the bus.
        clear_log();
        ack_delay = 0;
        rdpat = 32'hF0;
        @(negedge clk);
        miss = 1'b1;
        need_writeback = 1'b0;
        address = 16'h3340;
        begin
            int n;
            n = 0;
            while (n < 100 && !(mem.mem_req && mem.mem_addr == 16'h3350)) begin
                @(negedge clk);
                n++;
            end
            check("reach_beat4", 256'(n < 100), 256'(1));
        end
        #1;
        rst = 1'b1;
        miss = 1'b0;
        #1;
        check("mid_rst_req", 256'(mem.mem_req), 256'(0));
        check("mid_rst_stall", 256'(stall), 256'(0));
        check("mid_rst_done", 256'(refill_done), 256'(0));
        check("mid_rst_refill", refill_block, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_done", 256'(refill_done), 256'(0));
            check("post_rst_req", 256'(mem.mem_req), 256'(0));
        end

        r = vecs[0];
        r.rpat = 32'h11;
        run_miss(r, 1'b0);
        r = vecs[1];
        run_miss(r, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
